// File: rtl/timed_count_reader_if.sv
// Handshake and statistics bundle between a DSP timed counter
// and the consumer that reads, acknowledges and summarises it.
interface timed_count_reader_if #(
    parameter int COUNT_WIDTH = 25
) ();
    logic [COUNT_WIDTH-1:0] count_in;
    logic                   count_valid_in;
    logic                   interval_load_in;
    logic                   count_ack_out;
    logic                   clear_stats;
    logic [COUNT_WIDTH-1:0] count_latest;
    logic                   sample_valid;
    logic [COUNT_WIDTH-1:0] count_max;
    logic [COUNT_WIDTH-1:0] count_avg;
    logic                   avg_valid;

    modport master (
        output count_in,
        output count_valid_in,
        output interval_load_in,
        output clear_stats,
        input  count_ack_out,
        input  count_latest,
        input  sample_valid,
        input  count_max,
        input  count_avg,
        input  avg_valid
    );

    modport slave (
        input  count_in,
        input  count_valid_in,
        input  interval_load_in,
        input  clear_stats,
        output count_ack_out,
        output count_latest,
        output sample_valid,
        output count_max,
        output count_avg,
        output avg_valid
    );
endinterface

// File: rtl/timed_count_reader.sv
// Consumer end of an acknowledge-mode timed counter: settle, capture,
// ack, wait for valid to drop; keeps latest, max and block average.
module timed_count_reader #(
    parameter int COUNT_WIDTH   = 25,
    parameter int SETTLE_CYCLES = 1,
    parameter int ACK_LENGTH    = 2,
    parameter int AVG_LOG2      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    timed_count_reader_if.slave  bus
);
    localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int AW   = (ACK_LENGTH > 1) ? $clog2(ACK_LENGTH + 1) : 1;
    localparam int IW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACCW = COUNT_WIDTH + AVG_LOG2;

    localparam logic [SW-1:0] SETTLE_LAST =
        SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_LENGTH);
    localparam logic [IW-1:0] IDX_LAST = IW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        ACK,
        WAITCLR
    } state_e;

    state_e                 state_q, state_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic [AW-1:0]          ack_cnt_q, ack_cnt_d;
    logic                   ack_q, ack_d;
    logic [COUNT_WIDTH-1:0] latest_q, latest_d;
    logic                   sample_valid_q, sample_valid_d;
    logic [COUNT_WIDTH-1:0] max_q, max_d;
    logic [COUNT_WIDTH-1:0] avg_q, avg_d;
    logic                   avg_valid_q, avg_valid_d;
    logic [ACCW-1:0]        acc_q, acc_d;
    logic [IW-1:0]          idx_q, idx_d;

    logic                   capture;
    logic [COUNT_WIDTH-1:0] base_max;
    logic [ACCW-1:0]        base_acc;
    logic [IW-1:0]          base_idx;
    logic [ACCW-1:0]        sum;

    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        ack_cnt_d      = ack_cnt_q;
        ack_d          = ack_q;
        latest_d       = latest_q;
        sample_valid_d = 1'b0;
        capture        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.count_valid_in) begin
                    settle_d = '0;
                    state_d  = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
                end
            end
            SETTLE: begin
                if (!bus.count_valid_in || bus.interval_load_in) begin
                    state_d = IDLE;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            CAPTURE: begin
                if (bus.interval_load_in) begin
                    state_d = IDLE;
                end else begin
                    capture        = 1'b1;
                    latest_d       = bus.count_in;
                    sample_valid_d = 1'b1;
                    ack_d          = 1'b1;
                    ack_cnt_d      = AW'(1);
                    state_d        = ACK;
                end
            end
            // The capture edge already counts as the first ack cycle.
            ACK: begin
                if (ack_cnt_q == ACK_LAST) begin
                    ack_d   = 1'b0;
                    state_d = WAITCLR;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            WAITCLR: begin
                if (!bus.count_valid_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear on a capture edge makes that sample the first of the new block.
    always_comb begin
        base_max    = bus.clear_stats ? '0 : max_q;
        base_acc    = bus.clear_stats ? '0 : acc_q;
        base_idx    = bus.clear_stats ? '0 : idx_q;
        sum         = base_acc + ACCW'(bus.count_in);
        max_d       = base_max;
        acc_d       = base_acc;
        idx_d       = base_idx;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;

        if (capture) begin
            if (bus.count_in > base_max) begin
                max_d = bus.count_in;
            end
            if (base_idx == IDX_LAST) begin
                avg_d       = COUNT_WIDTH'(sum >> AVG_LOG2);
                avg_valid_d = 1'b1;
                acc_d       = '0;
                idx_d       = '0;
            end else begin
                acc_d = sum;
                idx_d = base_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            settle_q       <= '0;
            ack_cnt_q      <= '0;
            ack_q          <= 1'b0;
            latest_q       <= '0;
            sample_valid_q <= 1'b0;
            max_q          <= '0;
            avg_q          <= '0;
            avg_valid_q    <= 1'b0;
            acc_q          <= '0;
            idx_q          <= '0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            ack_cnt_q      <= ack_cnt_d;
            ack_q          <= ack_d;
            latest_q       <= latest_d;
            sample_valid_q <= sample_valid_d;
            max_q          <= max_d;
            avg_q          <= avg_d;
            avg_valid_q    <= avg_valid_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
        end
    end

    assign bus.count_ack_out = ack_q;
    assign bus.count_latest  = latest_q;
    assign bus.sample_valid  = sample_valid_q;
    assign bus.count_max     = max_q;
    assign bus.count_avg     = avg_q;
    assign bus.avg_valid     = avg_valid_q;
endmodule

// File: tb/tb_timed_count_reader.sv
// Randomised and directed bench for timed_count_reader with a
// queue-based statistics model (SETTLE=1, ACK=2, 4-sample average).
module tb_timed_count_reader;
    localparam int CW = 25;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // model of the statistics
    logic [CW-1:0] m_max;
    logic [CW-1:0] m_avg;
    logic [CW-1:0] m_blk[$];

    timed_count_reader_if #(.COUNT_WIDTH(CW)) bus ();

    timed_count_reader #(
        .COUNT_WIDTH  (CW),
        .SETTLE_CYCLES(1),
        .ACK_LENGTH   (2),
        .AVG_LOG2     (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_max = '0;
        m_avg = '0;
        m_blk.delete();
    endtask

    // returns 1 when this sample completes an averaging block
    function automatic bit model_capture(logic [CW-1:0] v, bit clr);
        logic [CW+1:0] s;
        if (clr) begin
            m_max = '0;
            m_blk.delete();
        end
        if (v > m_max) m_max = v;
        m_blk.push_back(v);
        if (m_blk.size() == 4) begin
            s = '0;
            foreach (m_blk[k]) s += {2'b00, m_blk[k]};
            m_avg = CW'(s / 4);
            m_blk.delete();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic apply_reset();
        bus.count_in         = '0;
        bus.count_valid_in   = 1'b0;
        bus.interval_load_in = 1'b0;
        bus.clear_stats      = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    // One full transaction; valid held `hold` extra cycles after ack ends.
    task automatic do_txn(input logic [CW-1:0] v, input int hold,
                          input bit clr);
        int sv_n, sv_at, ack_n, ack_first, av_n, sv_late;
        logic [CW-1:0] lat, mx, avg;
        bit exp_av;
        sv_n = 0; sv_at = -1; ack_n = 0; ack_first = -1; av_n = 0;
        sv_late = 0;
        lat = '0; mx = '0; avg = '0;
        bus.count_in       = v;
        bus.count_valid_in = 1'b1;
        for (int i = 1; i <= 5 + hold; i++) begin
            tick();
            bus.clear_stats = (clr && i == 2);
            if (bus.sample_valid) begin
                sv_n++;
                sv_at = i;
                lat = bus.count_latest;
                mx  = bus.count_max;
                avg = bus.count_avg;
            end
            if (bus.count_ack_out) begin
                ack_n++;
                if (ack_first < 0) ack_first = i;
            end
            if (bus.avg_valid) av_n++;
        end
        bus.count_valid_in = 1'b0;
        bus.count_in = CW'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.sample_valid || bus.count_ack_out) sv_late++;
        end
        exp_av = model_capture(v, clr);

        checks++;
        if (sv_n !== 1 || sv_at !== 3) begin
            errors++;
            $display("FAIL txn_sample: count %0d at %0d, need 1 at 3",
                     sv_n, sv_at);
        end
        checks++;
        if (ack_n !== 2 || ack_first !== 3) begin
            errors++;
            $display("FAIL txn_ack: %0d cycles from %0d, need 2 from 3",
                     ack_n, ack_first);
        end
        checks++;
        if (lat !== v) begin
            errors++;
            $display("FAIL txn_latest: got %h need %h", lat, v);
        end
        checks++;
        if (mx !== m_max) begin
            errors++;
            $display("FAIL txn_max: got %h need %h", mx, m_max);
        end
        checks++;
        if (av_n !== int'(exp_av) || (exp_av && avg !== m_avg)) begin
            errors++;
            $display("FAIL txn_avg: strobes %0d avg %h, need %0d avg %h",
                     av_n, avg, exp_av, m_avg);
        end
        checks++;
        if (sv_late !== 0 || bus.count_avg !== m_avg) begin
            errors++;
            $display("FAIL txn_after: late %0d avg %h, need 0 avg %h",
                     sv_late, bus.count_avg, m_avg);
        end
    endtask

    task automatic test_reset();
        bus.count_in         = 25'h1abcdef;
        bus.count_valid_in   = 1'b0;
        bus.interval_load_in = 1'b0;
        bus.clear_stats      = 1'b0;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({bus.count_ack_out, bus.count_latest, bus.sample_valid,
             bus.count_max, bus.count_avg, bus.avg_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack %b lat %h max %h avg %h, need 0",
                     bus.count_ack_out, bus.count_latest, bus.count_max,
                     bus.count_avg);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        do_txn(25'd1234, 1, 1'b0);
        checks++;
        if (bus.count_latest !== 25'd1234) begin
            errors++;
            $display("FAIL basic_latest: got %0d need 1234", bus.count_latest);
        end
    endtask

    task automatic test_stuck_valid();
        do_txn(25'd777, 10, 1'b0);
    endtask

    task automatic test_average();
        apply_reset();
        do_txn(25'd10, 0, 1'b0);
        do_txn(25'd11, 0, 1'b0);
        do_txn(25'd13, 0, 1'b0);
        do_txn(25'd15, 0, 1'b0);
        checks++;
        if (bus.count_avg !== 25'd12 || bus.count_max !== 25'd15) begin
            errors++;
            $display("FAIL avg_block: avg %0d max %0d, need 12 and 15",
                     bus.count_avg, bus.count_max);
        end
    endtask

    task automatic test_clear_stats();
        apply_reset();
        do_txn(25'd100, 0, 1'b0);
        do_txn(25'd7, 0, 1'b1);
        checks++;
        if (bus.count_max !== 25'd7) begin
            errors++;
            $display("FAIL clear_max: got %0d need 7", bus.count_max);
        end
        do_txn(25'd9, 0, 1'b0);
        do_txn(25'd9, 0, 1'b0);
        do_txn(25'd11, 0, 1'b0);
        checks++;
        if (bus.count_avg !== 25'd9) begin
            errors++;
            $display("FAIL clear_avg: got %0d need 9", bus.count_avg);
        end
    endtask

    task automatic test_interval_abort();
        int bad;
        bad = 0;
        bus.count_in       = 25'd555;
        bus.count_valid_in = 1'b1;
        tick();
        bus.count_valid_in   = 1'b0;
        bus.interval_load_in = 1'b1;
        tick();
        if (bus.sample_valid || bus.count_ack_out) bad++;
        bus.interval_load_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.sample_valid || bus.count_ack_out) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_settle: %0d capture/ack cycles, need 0", bad);
        end
        do_txn(25'd42, 0, 1'b0);
    endtask

    task automatic test_carry_and_reset_in_ack();
        apply_reset();
        bus.count_in       = 25'h1000000;
        bus.count_valid_in = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.count_max !== 25'h1000000 || bus.count_ack_out !== 1'b1) begin
            errors++;
            $display("FAIL carry_max: max %h ack %b, need 1000000 and 1",
                     bus.count_max, bus.count_ack_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.count_ack_out, bus.count_latest, bus.sample_valid,
             bus.count_max, bus.count_avg, bus.avg_valid} !== '0) begin
            errors++;
            $display("FAIL reset_in_ack: ack %b lat %h max %h, need all 0",
                     bus.count_ack_out, bus.count_latest, bus.count_max);
        end
        bus.count_valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        do_txn(25'd300, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [CW-1:0] v;
        for (int n = 0; n < 24; n++) begin
            v = CW'($urandom);
            if ($urandom_range(0, 5) == 0) v = 25'h1000000;
            do_txn(v, $urandom_range(0, 4), ($urandom_range(0, 6) == 0));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_stuck_valid();
        test_average();
        test_clear_stats();
        test_interval_abort();
        test_carry_and_reset_in_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
